// File: rtl/rpc_match_ctrl.sv
// rpc_match_ctrl: rock-paper-scissors match sequencer with per-round judging and match scoring
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start                      begin a match (honoured in IDLE and DONE only)
//   inA_valid/inA/inA_ready    player A one-hot move handshake (bit0 rock, bit1 paper, bit2 scissors)
//   inB_valid/inB/inB_ready    player B, same as A
//   busy                       match in progress
//   round_done, tie/winA/winB  one-cycle round result
//   scoreA, scoreB, round_cnt  running wins and completed rounds
//   match_done, match_win*/tie match outcome level
module rpc_match_ctrl #(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int MAX_ROUNDS    = 9,
  parameter int TIMEOUT       = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       inA_valid,
  input  logic [2:0] inA,
  output logic       inA_ready,
  input  logic       inB_valid,
  input  logic [2:0] inB,
  output logic       inB_ready,
  output logic       busy,
  output logic       round_done,
  output logic       tie,
  output logic       winA,
  output logic       winB,
  output logic [3:0] scoreA,
  output logic [3:0] scoreB,
  output logic [3:0] round_cnt,
  output logic       match_done,
  output logic       match_winA,
  output logic       match_winB,
  output logic       match_tie
);
  typedef enum logic [2:0] {IDLE, COLLECT, JUDGE, RESULT, DONE} state_e;
  state_e state_q, state_d;
  logic cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  logic rdy_a_q, rdy_a_d, rdy_b_q, rdy_b_d;
  logic [2:0] move_a_q, move_a_d, move_b_q, move_b_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [3:0] score_a_q, score_a_d, score_b_q, score_b_d, rcnt_q, rcnt_d;
  // {tie, winA, winB} of the last judged round
  logic [2:0] res_q, res_d;
  logic acc_a, acc_b, val_a, val_b, beat_a, beat_b, tmo, ra, rb;
  logic [8:0] tnext;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cap_a_q   <= 1'b0;
      cap_b_q   <= 1'b0;
      rdy_a_q   <= 1'b0;
      rdy_b_q   <= 1'b0;
      move_a_q  <= '0;
      move_b_q  <= '0;
      tcnt_q    <= '0;
      score_a_q <= '0;
      score_b_q <= '0;
      rcnt_q    <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cap_a_q   <= cap_a_d;
      cap_b_q   <= cap_b_d;
      rdy_a_q   <= rdy_a_d;
      rdy_b_q   <= rdy_b_d;
      move_a_q  <= move_a_d;
      move_b_q  <= move_b_d;
      tcnt_q    <= tcnt_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      rcnt_q    <= rcnt_d;
      res_q     <= res_d;
    end
  end
  // A move counts only if it was captured and is exactly one-hot; a missing move after timeout is invalid
  assign val_a  = cap_a_q && (move_a_q == 3'b001 || move_a_q == 3'b010 || move_a_q == 3'b100);
  assign val_b  = cap_b_q && (move_b_q == 3'b001 || move_b_q == 3'b010 || move_b_q == 3'b100);
  assign beat_a = (move_a_q == 3'b001 && move_b_q == 3'b100) || (move_a_q == 3'b010 && move_b_q == 3'b001) ||
                  (move_a_q == 3'b100 && move_b_q == 3'b010);
  assign beat_b = (move_b_q == 3'b001 && move_a_q == 3'b100) || (move_b_q == 3'b010 && move_a_q == 3'b001) ||
                  (move_b_q == 3'b100 && move_a_q == 3'b010);
  assign ra     = (val_a && val_b) ? beat_a : (val_a && !val_b);
  assign rb     = (val_a && val_b) ? beat_b : (val_b && !val_a);
  assign acc_a  = rdy_a_q && inA_valid;
  assign acc_b  = rdy_b_q && inB_valid;
  // Fires on the TIMEOUT-th COLLECT cycle so COLLECT lasts exactly TIMEOUT cycles
  assign tnext  = {1'b0, tcnt_q} + 9'd1;
  assign tmo    = (TIMEOUT != 0) && (tnext == 9'(TIMEOUT));
  always_comb begin
    state_d   = state_q;
    cap_a_d   = cap_a_q;
    cap_b_d   = cap_b_q;
    move_a_d  = move_a_q;
    move_b_d  = move_b_q;
    tcnt_d    = tcnt_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    rcnt_d    = rcnt_q;
    res_d     = res_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d   = COLLECT;
        cap_a_d   = 1'b0;
        cap_b_d   = 1'b0;
        tcnt_d    = '0;
        score_a_d = '0;
        score_b_d = '0;
        rcnt_d    = '0;
      end
      COLLECT: begin
        tcnt_d   = tcnt_q + 8'd1;
        cap_a_d  = cap_a_q || acc_a;
        cap_b_d  = cap_b_q || acc_b;
        move_a_d = acc_a ? inA : move_a_q;
        move_b_d = acc_b ? inB : move_b_q;
        state_d  = ((cap_a_d && cap_b_d) || tmo) ? JUDGE : COLLECT;
      end
      JUDGE: begin
        res_d     = {!ra && !rb, ra, rb};
        score_a_d = score_a_q + {3'b000, ra};
        score_b_d = score_b_q + {3'b000, rb};
        rcnt_d    = rcnt_q + 4'd1;
        state_d   = RESULT;
      end
      RESULT: begin
        state_d = (score_a_q == 4'(ROUNDS_TO_WIN) || score_b_q == 4'(ROUNDS_TO_WIN) ||
                   rcnt_q == 4'(MAX_ROUNDS)) ? DONE : COLLECT;
        cap_a_d = 1'b0;
        cap_b_d = 1'b0;
        tcnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Ready is registered: it reflects the state and capture flags being entered
  assign rdy_a_d = (state_d == COLLECT) && !cap_a_d;
  assign rdy_b_d = (state_d == COLLECT) && !cap_b_d;
  always_comb begin
    inA_ready  = rdy_a_q;
    inB_ready  = rdy_b_q;
    busy       = state_q != IDLE && state_q != DONE;
    round_done = state_q == RESULT;
    tie        = round_done && res_q[2];
    winA       = round_done && res_q[1];
    winB       = round_done && res_q[0];
    scoreA     = score_a_q;
    scoreB     = score_b_q;
    round_cnt  = rcnt_q;
    match_done = state_q == DONE;
    // Only one score can reach ROUNDS_TO_WIN, and it is then strictly the higher one
    match_winA = match_done && score_a_q > score_b_q;
    match_winB = match_done && score_b_q > score_a_q;
    match_tie  = match_done && score_a_q == score_b_q;
  end
endmodule
